// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes and FSM state encoding.
package load_store_unit_pkg;

    // Size codes carried on mem_byte_enable (LSB-aligned, before shifting to the lane)
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitResp,
        StDone
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane alignment for the load/store unit (module lsu_align).
// Store side: replicates byte/half data into every lane and shifts the strobe to the address.
// Load side: picks the addressed lane out of the bus word and sign/zero extends it.
// Purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BYTE_DATA_WIDTH = 4
) (
    input  logic [BYTE_DATA_WIDTH-1:0] st_size,
    input  logic [1:0]                 st_offset,
    input  logic [DATA_WIDTH-1:0]      st_wdata,
    output logic [BYTE_DATA_WIDTH-1:0] st_be,
    output logic [DATA_WIDTH-1:0]      st_wdata_lanes,
    output logic                       st_misaligned,
    input  logic [BYTE_DATA_WIDTH-1:0] ld_size,
    input  logic [1:0]                 ld_offset,
    input  logic                       ld_unsigned,
    input  logic [DATA_WIDTH-1:0]      ld_rdata,
    output logic [DATA_WIDTH-1:0]      ld_data
);

    logic [DATA_WIDTH-1:0] ld_shifted;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;

    // Store strobe/data generation and alignment check
    always_comb begin
        st_be          = '0;
        st_wdata_lanes = st_wdata;
        st_misaligned  = 1'b0;
        case (st_size)
            BE_BYTE: begin
                st_be          = BE_BYTE << st_offset;
                st_wdata_lanes = {BYTE_DATA_WIDTH{st_wdata[7:0]}};
            end
            BE_HALF: begin
                st_be          = BE_HALF << st_offset;
                st_wdata_lanes = {(BYTE_DATA_WIDTH / 2){st_wdata[15:0]}};
                st_misaligned  = st_offset[0];
            end
            BE_WORD: begin
                st_be         = BE_WORD;
                st_misaligned = |st_offset;
            end
            default: st_misaligned = 1'b1;
        endcase
    end

    // Load lane extract and sign/zero extension
    always_comb begin
        ld_shifted = ld_rdata >> {ld_offset, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = ld_shifted[15:0];
        case (ld_size)
            BE_BYTE: ld_data = {{(DATA_WIDTH - 8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            BE_HALF: ld_data = {{(DATA_WIDTH - 16){~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts a decode-side request under a four-phase handshake, runs one
// req/gnt/rvalid transaction on the data-memory bus and returns extended load data.
// Misaligned or illegal-size requests complete with mem_error and never touch the bus.
// Optional: define LSU_TIMEOUT_EN to add a bus watchdog that ends a stalled transaction
// with mem_error after TIMEOUT_CYCLES cycles in ISSUE/WAIT_RESP.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BYTE_DATA_WIDTH = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_req,
    input  logic                       mem_we,
    input  logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
    input  logic                       mem_unsigned,
    input  logic [DATA_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic                       mem_valid,
    output logic [DATA_WIDTH-1:0]      mem_rdata,
    output logic                       mem_error,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [BYTE_DATA_WIDTH-1:0] dmem_be,
    output logic [DATA_WIDTH-1:0]      dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    input  logic                       dmem_gnt,
    input  logic                       dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata
);

    lsu_state_e state_q, state_d;

    // Request attributes needed after IDLE to extract load data
    logic [BYTE_DATA_WIDTH-1:0] size_q, size_d;
    logic [1:0]                 offset_q, offset_d;
    logic                       unsigned_q, unsigned_d;

    logic                       mem_valid_q, mem_valid_d;
    logic [DATA_WIDTH-1:0]      mem_rdata_q, mem_rdata_d;
    logic                       mem_error_q, mem_error_d;
    logic                       dmem_req_q, dmem_req_d;
    logic                       dmem_we_q, dmem_we_d;
    logic [BYTE_DATA_WIDTH-1:0] dmem_be_q, dmem_be_d;
    logic [DATA_WIDTH-1:0]      dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;

    logic [BYTE_DATA_WIDTH-1:0] st_be;
    logic [DATA_WIDTH-1:0]      st_wdata_lanes;
    logic                       st_misaligned;
    logic [DATA_WIDTH-1:0]      ld_data;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    lsu_align #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BYTE_DATA_WIDTH (BYTE_DATA_WIDTH)
    ) u_align (
        .st_size        (mem_byte_enable),
        .st_offset      (mem_addr[1:0]),
        .st_wdata       (mem_wdata),
        .st_be          (st_be),
        .st_wdata_lanes (st_wdata_lanes),
        .st_misaligned  (st_misaligned),
        .ld_size        (size_q),
        .ld_offset      (offset_q),
        .ld_unsigned    (unsigned_q),
        .ld_rdata       (dmem_rdata),
        .ld_data        (ld_data)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        offset_d     = offset_q;
        unsigned_d   = unsigned_q;
        mem_valid_d  = mem_valid_q;
        mem_rdata_d  = mem_rdata_q;
        mem_error_d  = mem_error_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        case (state_q)
            StIdle: begin
                if (mem_req) begin
                    size_d       = mem_byte_enable;
                    offset_d     = mem_addr[1:0];
                    unsigned_d   = mem_unsigned;
                    dmem_we_d    = mem_we;
                    dmem_be_d    = st_be;
                    dmem_addr_d  = {mem_addr[DATA_WIDTH-1:2], 2'b00};
                    dmem_wdata_d = st_wdata_lanes;
                    if (st_misaligned) begin
                        state_d     = StDone;
                        mem_valid_d = 1'b1;
                        mem_error_d = 1'b1;
                        mem_rdata_d = '0;
                    end else begin
                        state_d    = StIssue;
                        dmem_req_d = 1'b1;
`ifdef LSU_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            StIssue: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (dmem_rvalid) begin
                        state_d     = StDone;
                        mem_valid_d = 1'b1;
                        mem_error_d = 1'b0;
                        mem_rdata_d = dmem_we_q ? '0 : ld_data;
                    end else begin
                        state_d = StWaitResp;
                    end
                end
            end
            StWaitResp: begin
                if (dmem_rvalid) begin
                    state_d     = StDone;
                    mem_valid_d = 1'b1;
                    mem_error_d = 1'b0;
                    mem_rdata_d = dmem_we_q ? '0 : ld_data;
                end
            end
            StDone: begin
                if (!mem_req) begin
                    state_d     = StIdle;
                    mem_valid_d = 1'b0;
                    mem_error_d = 1'b0;
                    mem_rdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef LSU_TIMEOUT_EN
        // Watchdog only matters while the bus has not yet completed this cycle
        if ((state_q == StIssue || state_q == StWaitResp) && state_d != StDone) begin
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                state_d     = StDone;
                mem_valid_d = 1'b1;
                mem_error_d = 1'b1;
                mem_rdata_d = '0;
                dmem_req_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            size_q       <= '0;
            offset_q     <= '0;
            unsigned_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_rdata_q  <= '0;
            mem_error_q  <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            offset_q     <= offset_d;
            unsigned_q   <= unsigned_d;
            mem_valid_q  <= mem_valid_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_error_q  <= mem_error_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign mem_valid  = mem_valid_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_error  = mem_error_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed load/store vectors against an
// arithmetic reference model, a bus responder with programmable gnt/rvalid delays,
// and literal expectations for the hand-computed cases.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_byte_enable;
    logic        mem_unsigned;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_byte_enable (mem_byte_enable),
        .mem_unsigned    (mem_unsigned),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_valid       (mem_valid),
        .mem_rdata       (mem_rdata),
        .mem_error       (mem_error),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_be         (dmem_be),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_gnt        (dmem_gnt),
        .dmem_rvalid     (dmem_rvalid),
        .dmem_rdata      (dmem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model expectations for the transaction in flight
    bit          check_en = 1'b0;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic        exp_err, exp_nobus;

    // Responder configuration and observations
    logic [31:0] bus_rdata = '0;
    int          cfg_rv = 0;
    int          g_cnt = 0;
    bit          gnt_given = 1'b1;
    bit          rv_pending = 1'b0;
    int          rv_cnt = 0;
    int          req_cycles = 0, gnt_cnt = 0, valid_cycles = 0;
    logic [3:0]  seen_be = '0;
    logic [31:0] seen_addr = '0, seen_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_bad(input logic [3:0] be, input logic [31:0] a);
        if (be == 4'd1) return 1'b0;
        if (be == 4'd3) return (a % 2) != 0;
        if (be == 4'd15) return (a % 4) != 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] be, input logic [31:0] a);
        logic [31:0] v;
        v = 32'(be) * (32'd2 ** (a % 4));
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] be, input logic [31:0] w);
        if (be == 4'd1) return (w % 256) * 32'h0101_0101;
        if (be == 4'd3) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] be, input logic uns,
                                               input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        v = r / (32'd256 ** (a % 4));
        if (be == 4'd1) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (be == 4'd3) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // Bus responder: drives gnt/rvalid for the cycle after each falling edge
    initial begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        forever begin
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (dmem_req) begin
                req_cycles++;
                seen_be    = dmem_be;
                seen_addr  = dmem_addr;
                seen_wdata = dmem_wdata;
            end
            if (mem_valid) valid_cycles++;
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = bus_rdata;
                    rv_pending  = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (dmem_req && !gnt_given) begin
                if (g_cnt == 0) begin
                    dmem_gnt  = 1'b1;
                    gnt_given = 1'b1;
                    gnt_cnt++;
                    if (cfg_rv == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = bus_rdata;
                    end else if (cfg_rv > 0) begin
                        rv_pending = 1'b1;
                        rv_cnt     = cfg_rv - 1;
                    end
                end else begin
                    g_cnt--;
                end
            end
        end
    end

    // Compare process: every cycle the outputs are meaningful
    always @(negedge clk) begin
        if (check_en) begin
            if (dmem_req) begin
                if (exp_nobus) begin
                    chk("bus_on_misaligned", 32'(dmem_req), 32'd0);
                end else begin
                    chk("dmem_addr", dmem_addr, exp_addr);
                    chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (mem_valid) begin
                chk("mem_rdata", mem_rdata, exp_rd);
                chk("mem_error", 32'(mem_error), 32'(exp_err));
            end
        end
    end

    task automatic run_txn(input logic we, input logic [3:0] be, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int gwait, input int rwait,
                           input bit to, output int lat, output logic [31:0] rd,
                           output logic err);
        logic bad;
        bad       = model_bad(be, addr);
        exp_we    = we;
        exp_be    = model_be(be, addr);
        exp_addr  = addr - (addr % 4);
        exp_wdata = model_wdata(be, wdata);
        exp_nobus = bad;
        exp_err   = bad || to;
        exp_rd    = (bad || we || to) ? 32'd0 : model_load(be, uns, addr, rdata);
        bus_rdata = rdata;
        cfg_rv    = rwait;
        g_cnt     = gwait;
        gnt_given = 1'b0;
        req_cycles = 0;
        gnt_cnt    = 0;
        valid_cycles = 0;
        check_en  = 1'b1;
        @(posedge clk);
        #1;
        mem_req         = 1'b1;
        mem_we          = we;
        mem_byte_enable = be;
        mem_unsigned    = uns;
        mem_addr        = addr;
        mem_wdata       = wdata;
        lat = 0;
        forever begin
            @(negedge clk);
            if (mem_valid || lat >= 300) break;
            lat++;
        end
        if (!mem_valid) chk("completion_timeout", 32'(mem_valid), 32'd1);
        rd  = mem_rdata;
        err = mem_error;
        repeat (2) begin
            @(negedge clk);
            chk("valid_held", 32'(mem_valid), 32'd1);
        end
        @(posedge clk);
        #1 mem_req = 1'b0;
        @(negedge clk);
        chk("valid_until_drop", 32'(mem_valid), 32'd1);
        @(negedge clk);
        chk("valid_low_after_drop", 32'(mem_valid), 32'd0);
        check_en = 1'b0;
        gnt_given = 1'b1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        err;

    initial begin
        rst = 1'b1;
        mem_req = 1'b0; mem_we = 1'b0; mem_byte_enable = '0; mem_unsigned = 1'b0;
        mem_addr = '0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_error", 32'(mem_error), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);

        // SW 0x100, zero-wait bus
        run_txn(1'b1, 4'b1111, 1'b0, 32'h100, 32'hCAFE_BABE, 32'h0, 0, 0, 1'b0, lat, rd, err);
        chk("sw_latency", lat, 2);
        chk("sw_error", 32'(err), 32'd0);
        chk("sw_be_lit", 32'(seen_be), 32'hF);
        chk("sw_addr_lit", seen_addr, 32'h100);
        chk("sw_wdata_lit", seen_wdata, 32'hCAFE_BABE);

        // LB / LBU 0x203
        run_txn(1'b0, 4'b0001, 1'b0, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0, lat, rd, err);
        chk("lb_lit", rd, 32'hFFFF_FF80);
        run_txn(1'b0, 4'b0001, 1'b1, 32'h203, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0, lat, rd, err);
        chk("lbu_lit", rd, 32'h0000_0080);

        // SH 0x002
        run_txn(1'b1, 4'b0011, 1'b0, 32'h002, 32'h0000_1234, 32'h0, 0, 0, 1'b0, lat, rd, err);
        chk("sh_be_lit", 32'(seen_be), 32'hC);
        chk("sh_wdata_lit", seen_wdata, 32'h1234_1234);

        // LW misaligned: error, no bus access
        run_txn(1'b0, 4'b1111, 1'b0, 32'h101, 32'h0, 32'h5555_5555, 0, 0, 1'b0, lat, rd, err);
        chk("lw_mis_error", 32'(err), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_no_req", req_cycles, 0);
        chk("lw_mis_latency", lat, 1);

        // Delayed gnt (3) and rvalid (2 after gnt)
        run_txn(1'b0, 4'b1111, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 3, 2, 1'b0, lat, rd, err);
        chk("slow_req_cycles", req_cycles, 4);
        chk("slow_gnt_count", gnt_cnt, 1);
        chk("slow_latency", lat, 7);
        chk("slow_rdata_lit", rd, 32'h1234_5678);

        // Half loads and a byte store into lane 1
        run_txn(1'b0, 4'b0011, 1'b0, 32'h006, 32'h0, 32'h8001_5555, 0, 1, 1'b0, lat, rd, err);
        chk("lh_lit", rd, 32'hFFFF_8001);
        run_txn(1'b0, 4'b0011, 1'b1, 32'h004, 32'h0, 32'h1234_F00D, 1, 0, 1'b0, lat, rd, err);
        chk("lhu_lit", rd, 32'h0000_F00D);
        run_txn(1'b1, 4'b0001, 1'b0, 32'h101, 32'hFFFF_FFA5, 32'h0, 0, 0, 1'b0, lat, rd, err);
        chk("sb_be_lit", 32'(seen_be), 32'h2);
        chk("sb_wdata_lit", seen_wdata, 32'hA5A5_A5A5);

        // Misaligned half and illegal size code
        run_txn(1'b1, 4'b0011, 1'b0, 32'h003, 32'hFFFF, 32'h0, 0, 0, 1'b0, lat, rd, err);
        chk("sh_mis_error", 32'(err), 32'd1);
        run_txn(1'b0, 4'b0101, 1'b0, 32'h000, 32'h0, 32'h0, 0, 0, 1'b0, lat, rd, err);
        chk("bad_size_error", 32'(err), 32'd1);
        chk("bad_size_no_req", req_cycles, 0);

        // Model-checked aligned mix with varying bus delays
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  be;
            logic [31:0] a;
            int          sz;
            sz = $urandom_range(0, 2);
            a  = $urandom & 32'hFFFF_FFFC;
            if (sz == 0) begin be = 4'b0001; a = a + $urandom_range(0, 3); end
            else if (sz == 1) begin be = 4'b0011; a = a + 2 * $urandom_range(0, 1); end
            else be = 4'b1111;
            run_txn(1'($urandom_range(0, 1)), be, 1'($urandom_range(0, 1)), a, $urandom,
                    $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, lat, rd, err);
            chk("mix_error", 32'(err), 32'd0);
        end

        // mem_req dropped while in ISSUE: one-cycle completion pulse
        exp_we = 1'b1; exp_be = 4'hF; exp_addr = 32'h10; exp_wdata = 32'h1111_2222;
        exp_nobus = 1'b0; exp_err = 1'b0; exp_rd = 32'h0;
        bus_rdata = 32'h0; cfg_rv = 0; g_cnt = 2; gnt_given = 1'b0;
        gnt_cnt = 0; valid_cycles = 0; check_en = 1'b1;
        @(posedge clk);
        #1 mem_req = 1'b1; mem_we = 1'b1; mem_byte_enable = 4'hF;
        mem_addr = 32'h10; mem_wdata = 32'h1111_2222;
        @(posedge clk);
        #1 mem_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("drop_valid_pulse", valid_cycles, 1);
        chk("drop_gnt_count", gnt_cnt, 1);
        check_en = 1'b0;
        gnt_given = 1'b1;

        // Reset in WAIT_RESP; the late rvalid must be ignored
        bus_rdata = 32'hDEAD_BEEF; cfg_rv = 5; g_cnt = 0; gnt_given = 1'b0;
        @(posedge clk);
        #1 mem_req = 1'b1; mem_we = 1'b0; mem_byte_enable = 4'hF; mem_addr = 32'h80;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; mem_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
        chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
        chk("midrst_dmem_addr", dmem_addr, 32'd0);
        chk("midrst_mem_rdata", mem_rdata, 32'd0);
        valid_cycles = 0;
        req_cycles   = 0;
        repeat (8) @(negedge clk);
        chk("late_rvalid_ignored", valid_cycles, 0);
        chk("late_rvalid_no_req", req_cycles, 0);
        gnt_given = 1'b1;

`ifdef LSU_TIMEOUT_EN
        // Response never arrives: watchdog completes with an error
        run_txn(1'b0, 4'b1111, 1'b0, 32'h200, 32'h0, 32'h0, 0, -1, 1'b1, lat, rd, err);
        chk("timeout_latency", lat, 65);
        chk("timeout_error", 32'(err), 32'd1);
        chk("timeout_rdata", rd, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
